// File: rtl/fifo_wr_arb_pkg.sv
// Shared types for the FIFO write-port arbiter.
// Provides the arbiter state encoding and index-width helper.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

  localparam int BC_W = 5;

  function automatic int gid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker.
// Searches from last+1 upward (mod N_REQ) for the first request.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GW    = gid_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last,
  output logic [GW-1:0]    win,
  output logic             any
);

  // Walk farthest-to-nearest so the nearest hit overrides.
  always_comb begin
    logic [GW-1:0] idx;
    idx = '0;
    win = '0;
    any = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = GW'((int'(last) + k) % N_REQ);
      if (req[idx]) begin
        win = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of sync_fifo.
// Bounded bursts, registered write port, in-flight space check.
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int F_WIDTH   = 32,
  parameter int P_N       = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*F_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     wr_en,
  output logic [F_WIDTH-1:0]       wr_data,
  input  logic                     full,
  input  logic [P_N:0]             room_avail,
  output logic                     grant_vld,
  output logic [gid_w(N_REQ)-1:0]  grant_id
);

  localparam int GW = gid_w(N_REQ);

  arb_state_e          state;
  arb_state_e          state_nx;
  logic [GW-1:0]       last_grant;
  logic [BC_W-1:0]     burst_cnt;
  logic [GW-1:0]       win;
  logic                any;
  logic                has_space;
  logic                cur_valid;
  logic                xfer;
  logic                burst_end;
  logic                start;
  logic                leave;
  logic [F_WIDTH-1:0]  words [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = req_data[g*F_WIDTH +: F_WIDTH];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .win  (win),
    .any  (any)
  );

  // A registered write is not yet counted in room_avail.
  assign has_space = !full &&
    (room_avail > {{P_N{1'b0}}, wr_en});

  assign grant_vld = (state == ARB_GRANT);
  assign cur_valid = req_valid[grant_id];
  assign xfer      = grant_vld && cur_valid && has_space;
  assign burst_end = (burst_cnt == BC_W'(MAX_BURST - 1));

  always_comb begin
    req_ready = '0;
    if (grant_vld && has_space)
      req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ARB_IDLE: begin
        if (enable && any)
          state_nx = ARB_GRANT;
      end
      ARB_GRANT: begin
        if (!cur_valid || (xfer && burst_end))
          state_nx = ARB_IDLE;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  assign start = (state == ARB_IDLE) &&
                 (state_nx == ARB_GRANT);
  assign leave = (state == ARB_GRANT) &&
                 (state_nx == ARB_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      grant_id   <= '0;
      burst_cnt  <= '0;
      last_grant <= GW'(N_REQ - 1);
    end else begin
      state <= state_nx;
      if (start) begin
        grant_id  <= win;
        burst_cnt <= '0;
      end else if (xfer) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (leave)
        last_grant <= grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_en <= xfer;
      if (xfer)
        wr_data <= words[grant_id];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb with a queue-based FIFO and producer model.
// Directed timing steps followed by a randomized traffic phase.
module tb_fifo_wr_arb;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int PN    = 4;
  localparam int MB    = 4;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           wr_en;
  logic [W-1:0]   wr_data;
  logic           full;
  logic [PN:0]    room_avail;
  logic           grant_vld;
  logic [1:0]     grant_id;

  fifo_wr_arb #(
    .N_REQ     (N),
    .F_WIDTH   (W),
    .P_N       (PN),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .room_avail (room_avail),
    .grant_vld  (grant_vld),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  // FIFO model
  int         cnt = 0;
  logic       rd = 1'b0;
  logic [W-1:0] wlog[$];
  int         wcount = 0;
  int         ovf = 0;

  assign room_avail = (PN+1)'(DEPTH - cnt);
  assign full       = (cnt == DEPTH);

  always @(posedge clk) begin
    if (wr_en) begin
      wcount++;
      if (cnt >= DEPTH) ovf++;
      else wlog.push_back(wr_data);
    end
    cnt <= cnt + ((wr_en && cnt < DEPTH) ? 1 : 0)
               - ((rd && cnt > 0) ? 1 : 0);
  end

  // producer model
  logic [W-1:0] pq[N][$];
  logic [W-1:0] expq[N][$];
  int  gap[N];
  bit  rnd_gaps = 0;
  int  seq = 0;

  // observation
  int npass = 0, nfail = 0, nchk = 0;
  int cyc = 0;
  logic [N-1:0] s_rdy, xf;
  logic s_gvld, s_wr;
  logic [1:0] s_gid;
  logic prev_gvld = 1'b0;
  int glog[$];
  int onehot_bad = 0;
  int cur_burst = 0, max_burst = 0, last_xfer = 0;
  logic [15:0] h_rdy, h_gv, h_wr;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add(int p, int n);
    logic [W-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = {8'(p), 24'(seq)};
      seq++;
      pq[p].push_back(w);
      expq[p].push_back(w);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0 && gap[i] == 0) begin
        req_valid[i] = 1'b1;
        req_data[i*W +: W] = pq[i][0];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s_rdy  = req_ready;
    s_gvld = grant_vld;
    s_gid  = grant_id;
    s_wr   = wr_en;
    xf     = req_valid & req_ready;
    if ($countones(req_ready) > 1) onehot_bad++;
    if (s_gvld && !prev_gvld) begin
      glog.push_back(int'(s_gid));
      cur_burst = 0;
    end
    prev_gvld = s_gvld;
    if (xf != 0) begin
      cur_burst++;
      if (cur_burst > max_burst) max_burst = cur_burst;
      last_xfer = cyc;
    end
    h_rdy = {h_rdy[14:0], |s_rdy};
    h_gv  = {h_gv[14:0], s_gvld};
    h_wr  = {h_wr[14:0], s_wr};
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (xf[i]) begin
        void'(pq[i].pop_front());
        if (rnd_gaps) gap[i] = $urandom_range(0, 2);
      end else if (gap[i] > 0) begin
        gap[i]--;
      end
    end
    drive();
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++)
      if (pq[i].size() > 0) return 1'b1;
    return grant_vld;
  endfunction

  task automatic wait_done(int bound, string tag);
    int k = 0;
    while (busy() && k < bound) begin
      tick();
      k++;
    end
    chk({tag, "_timeout"}, 64'(k < bound), 64'd1);
    tick();
    tick();
  endtask

  // every written word must be the next one its producer sent
  task automatic check_streams(int from, string tag);
    logic [W-1:0] w;
    int p;
    for (int k = from; k < wlog.size(); k++) begin
      w = wlog[k];
      p = int'(w[31:24]);
      if (p < N && expq[p].size() > 0)
        chk({tag, "_order"}, 64'(w), 64'(expq[p].pop_front()));
      else
        chk({tag, "_stray"}, 64'(w), 64'hffff_ffff_ffff);
    end
    for (int i = 0; i < N; i++) begin
      chk({tag, "_left"}, 64'(expq[i].size()), 64'd0);
      expq[i].delete();
    end
  endtask

  task automatic hist_clr();
    h_rdy = '0;
    h_gv  = '0;
    h_wr  = '0;
  endtask

  initial begin
    int mark, gmark, wmark, c0, gv_cnt, last_m;
    int rem[N];
    logic [W-1:0] tq[N][$];
    int exp_order[$];
    logic [W-1:0] exp_stream[$];

    for (int i = 0; i < N; i++) gap[i] = 0;
    req_valid = '0;
    req_data  = '0;
    enable    = 1'b1;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_gvld", 64'(grant_vld), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // single producer, 6 words: bursts of 4 then 2
    mark = wlog.size();
    add(0, 6);
    drive();
    hist_clr();
    for (int k = 0; k < 10; k++) tick();
    chk("t1_ready", 64'(h_rdy[9:0]), 64'b0111101110);
    chk("t1_gvld", 64'(h_gv[9:0]), 64'b0111101110);
    chk("t1_wr_en", 64'(h_wr[9:0]), 64'b0011110110);
    chk("t1_count", 64'(wlog.size() - mark), 64'd6);
    check_streams(mark, "t1");

    // all four producers continuously valid
    rd = 1'b1;
    mark  = wlog.size();
    gmark = glog.size();
    for (int i = 0; i < N; i++) add(i, 8);
    for (int i = 0; i < N; i++) begin
      tq[i] = pq[i];
      rem[i] = 8;
    end
    last_m = 0;
    while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (last_m + k) % N;
        if (rem[p] > 0) begin
          int take;
          take = (rem[p] < MB) ? rem[p] : MB;
          exp_order.push_back(p);
          for (int j = 0; j < take; j++)
            exp_stream.push_back(tq[p].pop_front());
          rem[p] -= take;
          last_m = p;
          break;
        end
      end
    end
    c0 = cyc;
    drive();
    wait_done(200, "t2");
    chk("t2_span", 64'(last_xfer - c0),
        64'((MB + 1) * exp_order.size() - 1));
    chk("t2_ngrants", 64'(glog.size() - gmark),
        64'(exp_order.size()));
    for (int k = 0; k < exp_order.size(); k++)
      if (gmark + k < glog.size())
        chk("t2_gorder", 64'(glog[gmark + k]),
            64'(exp_order[k]));
    chk("t2_nwords", 64'(wlog.size() - mark),
        64'(exp_stream.size()));
    for (int k = 0; k < exp_stream.size(); k++)
      if (mark + k < wlog.size())
        chk("t2_stream", 64'(wlog[mark + k]),
            64'(exp_stream[k]));
    check_streams(mark, "t2");

    // no reads: exactly DEPTH writes, then one read admits one
    begin
      int k = 0;
      while (cnt > 0 && k < 100) begin tick(); k++; end
    end
    rd = 1'b0;
    chk("t3_empty", 64'(cnt), 64'd0);
    mark  = wlog.size();
    wmark = wcount;
    add(1, 20);
    drive();
    for (int k = 0; k < 40; k++) tick();
    chk("t3_writes", 64'(wcount - wmark), 64'(DEPTH));
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_ready_low", 64'(s_rdy), 64'd0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("t3_one_more", 64'(wcount - wmark), 64'(DEPTH + 1));
    chk("t3_ready_low2", 64'(s_rdy), 64'd0);
    chk("t3_ovf", 64'(ovf), 64'd0);
    rd = 1'b1;
    wait_done(200, "t3");
    check_streams(mark, "t3");

    // enable dropped on the second transfer of a burst
    mark  = wlog.size();
    gmark = glog.size();
    wmark = wcount;
    add(2, 8);
    drive();
    tick();
    tick();
    enable = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    gv_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (s_gvld) gv_cnt++;
    end
    chk("t4_no_grant", 64'(gv_cnt), 64'd0);
    chk("t4_burst", 64'(wcount - wmark), 64'(MB));
    chk("t4_ngrant", 64'(glog.size() - gmark), 64'd1);
    enable = 1'b1;
    wait_done(100, "t4");
    chk("t4_regrant", 64'(glog.size() - gmark), 64'd2);
    chk("t4_gid", 64'(glog[glog.size() - 1]), 64'd2);
    check_streams(mark, "t4");

    // asynchronous reset right after a transfer
    add(3, 8);
    drive();
    tick();
    tick();
    chk("t5_pre_wr_en", 64'(wr_en), 64'd1);
    chk("t5_pre_gvld", 64'(grant_vld), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_wr_en", 64'(wr_en), 64'd0);
    chk("t5_ready", 64'(req_ready), 64'd0);
    chk("t5_gvld", 64'(grant_vld), 64'd0);
    chk("t5_gid", 64'(grant_id), 64'd0);
    chk("t5_wr_data", 64'(wr_data), 64'd0);
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      expq[i].delete();
      gap[i] = 0;
    end
    drive();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    mark  = wlog.size();
    gmark = glog.size();
    add(2, 1);
    add(0, 1);
    drive();
    wait_done(50, "t5");
    chk("t5_first_gid", 64'(glog[gmark]), 64'd0);
    chk("t5_second_gid", 64'(glog[gmark + 1]), 64'd2);
    check_streams(mark, "t5");

    // producer 3 drops valid after one word
    mark  = wlog.size();
    gmark = glog.size();
    add(3, 1);
    add(1, 2);
    drive();
    hist_clr();
    for (int k = 0; k < 6; k++) tick();
    chk("t6_gvld", 64'(h_gv[5:0]), 64'b011011);
    chk("t6_gid_a", 64'(glog[gmark]), 64'd3);
    chk("t6_gid_b", 64'(glog[gmark + 1]), 64'd1);
    wait_done(50, "t6");
    check_streams(mark, "t6");

    // randomized traffic
    rnd_gaps  = 1;
    max_burst = 0;
    mark = wlog.size();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++)
        add(i, int'($urandom_range(0, 12)));
      drive();
      for (int k = 0; k < 150; k++) begin
        rd = 1'($urandom_range(0, 1));
        enable = ($urandom_range(0, 7) != 0);
        tick();
      end
    end
    enable = 1'b1;
    rd = 1'b1;
    wait_done(1000, "t7");
    check_streams(mark, "t7");
    chk("t7_onehot", 64'(onehot_bad), 64'd0);
    chk("t7_burst_max", 64'(max_burst <= MB), 64'd1);
    chk("t7_ovf", 64'(ovf), 64'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
